// File: rtl/heap_arb_pkg.sv
// Shared heap definitions: op codes, sentinel data values and response source decode.
package heap_arb_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_READ    = 3'd1,
    OP_WRITE   = 3'd2,
    OP_ALLOC   = 3'd3,
    OP_FREE    = 3'd4,
    OP_REALLOC = 3'd5
  } op_e;

  localparam logic [15:0] UNDEF = 16'h0000;
  localparam logic [15:0] NIL   = 16'h0000;

  typedef enum logic [1:0] {
    RSP_UNDEF  = 2'd0,
    RSP_AADDR  = 2'd1,
    RSP_HRDATA = 2'd2
  } rsp_src_e;

  // Where the one-cycle-later response word comes from for a given op.
  function automatic rsp_src_e rsp_src(input logic [2:0] op);
    case (op)
      OP_READ:             rsp_src = RSP_HRDATA;
      OP_ALLOC, OP_REALLOC: rsp_src = RSP_AADDR;
      default:             rsp_src = RSP_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/heap_arb_if.sv
// Arbiter-to-heap-allocator port bundle; names are from the arbiter's point of view.
interface heap_arb_if #(
  parameter int DATA_SZ = 16
);
  logic               o_al;
  logic [DATA_SZ-1:0] o_adata;
  logic               o_fr;
  logic [DATA_SZ-1:0] o_faddr;
  logic               o_wr;
  logic [DATA_SZ-1:0] o_waddr;
  logic [DATA_SZ-1:0] o_wdata;
  logic               o_rd;
  logic [DATA_SZ-1:0] o_raddr;
  logic [DATA_SZ-1:0] i_aaddr;
  logic [DATA_SZ-1:0] i_hrdata;

  // Strobes are single-cycle commands with no ready; i_aaddr/i_hrdata are
  // valid exactly one cycle after o_al/o_rd respectively.
  modport master (
    output o_al, o_adata, o_fr, o_faddr, o_wr, o_waddr, o_wdata, o_rd, o_raddr,
    input  i_aaddr, i_hrdata
  );

  modport slave (
    input  o_al, o_adata, o_fr, o_faddr, o_wr, o_waddr, o_wdata, o_rd, o_raddr,
    output i_aaddr, i_hrdata
  );
endinterface

// File: rtl/heap_arb_rr_arb2.sv
// Two-way round-robin arbiter with an eligibility mask; pointer moves away from the last winner.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_elig,
  output logic [1:0] o_gnt
);
  logic r_ptr;

  // r_ptr names the client that wins a tie; an ineligible favourite is skipped.
  always_comb begin
    o_gnt = 2'b00;
    if (!r_ptr) begin
      o_gnt[0] = i_elig[0];
      o_gnt[1] = i_elig[1] & ~i_elig[0];
    end else begin
      o_gnt[1] = i_elig[1];
      o_gnt[0] = i_elig[0] & ~i_elig[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end
endmodule

// File: rtl/heap_arb.sv
// Two-client front end for a heap allocator: round-robin grant, credit-gated ALLOC,
// combinational heap strobes and a fixed one-cycle response path.
module heap_arb
  import heap_arb_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8,
  parameter int MEM_MAX = 1 << ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst,
  // Request side: a request is taken in the cycle o_rN is high (valid/ready);
  // the client may change or drop it in any cycle where o_rN is low.
  input  logic               i_v0,
  input  logic               i_v1,
  output logic               o_r0,
  output logic               o_r1,
  input  logic [2:0]         i_op0,
  input  logic [2:0]         i_op1,
  input  logic [DATA_SZ-1:0] i_addr0,
  input  logic [DATA_SZ-1:0] i_addr1,
  input  logic [DATA_SZ-1:0] i_data0,
  input  logic [DATA_SZ-1:0] i_data1,
  output logic               o_rv0,
  output logic               o_rv1,
  output logic [DATA_SZ-1:0] o_rdata,
  heap_arb_if.master         hp,
  output logic               o_empty
);
  localparam logic [ADDR_SZ:0] CRED_MAX = (ADDR_SZ + 1)'(MEM_MAX);

  logic [ADDR_SZ:0]   r_credits;
  logic [ADDR_SZ:0]   w_credits_nxt;
  logic               r_empty;
  logic               r_rv0;
  logic               r_rv1;
  rsp_src_e           r_src;
  logic [1:0]         w_elig;
  logic [1:0]         w_gnt;
  logic               w_acc;
  logic [2:0]         w_op;
  logic [DATA_SZ-1:0] w_addr;
  logic [DATA_SZ-1:0] w_data;

  assign w_elig[0] = i_v0 & ~i_rst & ((i_op0 != OP_ALLOC) | (r_credits != '0));
  assign w_elig[1] = i_v1 & ~i_rst & ((i_op1 != OP_ALLOC) | (r_credits != '0));

  rr_arb2 u_rr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_elig (w_elig),
    .o_gnt  (w_gnt)
  );

  assign o_r0   = w_gnt[0];
  assign o_r1   = w_gnt[1];
  assign w_acc  = |w_gnt;
  assign w_op   = w_gnt[1] ? i_op1   : i_op0;
  assign w_addr = w_gnt[1] ? i_addr1 : i_addr0;
  assign w_data = w_gnt[1] ? i_data1 : i_data0;

  // Illegal ops fall through the case and leave every strobe low.
  always_comb begin
    hp.o_al    = 1'b0;
    hp.o_adata = '0;
    hp.o_fr    = 1'b0;
    hp.o_faddr = '0;
    hp.o_wr    = 1'b0;
    hp.o_waddr = '0;
    hp.o_wdata = '0;
    hp.o_rd    = 1'b0;
    hp.o_raddr = '0;
    if (w_acc) begin
      case (w_op)
        OP_READ: begin
          hp.o_rd    = 1'b1;
          hp.o_raddr = w_addr;
        end
        OP_WRITE: begin
          hp.o_wr    = 1'b1;
          hp.o_waddr = w_addr;
          hp.o_wdata = w_data;
        end
        OP_ALLOC: begin
          hp.o_al    = 1'b1;
          hp.o_adata = w_data;
        end
        OP_FREE: begin
          hp.o_fr    = 1'b1;
          hp.o_faddr = w_addr;
        end
        OP_REALLOC: begin
          hp.o_al    = 1'b1;
          hp.o_adata = w_data;
          hp.o_fr    = 1'b1;
          hp.o_faddr = w_addr;
        end
        default: ;
      endcase
    end
  end

  // ALLOC is only granted with credits > 0, so the decrement cannot wrap.
  always_comb begin
    w_credits_nxt = r_credits;
    if (w_acc) begin
      if (w_op == OP_ALLOC) begin
        w_credits_nxt = r_credits - 1'b1;
      end else if ((w_op == OP_FREE) && (r_credits != CRED_MAX)) begin
        w_credits_nxt = r_credits + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_credits <= CRED_MAX;
      r_empty   <= (CRED_MAX == '0);
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_src     <= RSP_UNDEF;
    end else begin
      r_credits <= w_credits_nxt;
      r_empty   <= (w_credits_nxt == '0);
      r_rv0     <= w_gnt[0];
      r_rv1     <= w_gnt[1];
      r_src     <= rsp_src(w_op);
    end
  end

  assign o_empty = r_empty;

  // Gating with i_rst drops a response that would land in the reset cycle itself.
  assign o_rv0 = r_rv0 & ~i_rst;
  assign o_rv1 = r_rv1 & ~i_rst;

  always_comb begin
    o_rdata = '0;
    if (o_rv0 | o_rv1) begin
      case (r_src)
        RSP_AADDR:  o_rdata = hp.i_aaddr;
        RSP_HRDATA: o_rdata = hp.i_hrdata;
        default:    o_rdata = DATA_SZ'(UNDEF);
      endcase
    end
  end
endmodule

// File: tb/tb_heap_arb.sv
// Self-checking bench for heap_arb: heap model, reference arbiter/credit model,
// per-client expected-response queues and directed scenarios plus a random phase.
module tb_heap_arb;
  localparam int DATA_SZ = 16;
  localparam int ADDR_SZ = 8;
  localparam int MEM_MAX = 4;

  logic               clk;
  logic               rst;
  logic               v0, v1;
  logic               r0, r1;
  logic [2:0]         op0, op1;
  logic [DATA_SZ-1:0] addr0, addr1, data0, data1;
  logic               rv0, rv1;
  logic [DATA_SZ-1:0] rdata;
  logic               empty;

  heap_arb_if #(.DATA_SZ(DATA_SZ)) hp ();

  heap_arb #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .MEM_MAX(MEM_MAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_v0(v0), .i_v1(v1), .o_r0(r0), .o_r1(r1),
    .i_op0(op0), .i_op1(op1),
    .i_addr0(addr0), .i_addr1(addr1), .i_data0(data0), .i_data1(data1),
    .o_rv0(rv0), .o_rv1(rv1), .o_rdata(rdata),
    .hp(hp), .o_empty(empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, required finish before 100000");
    $fatal(1, "watchdog");
  end

  // ---------------- heap model ----------------
  always @(posedge clk) begin
    if (hp.o_rd) hp.i_hrdata <= hp.o_raddr ^ 16'hA5A5;
    if (hp.o_al) hp.i_aaddr  <= hp.o_adata + 16'h0100;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [DATA_SZ-1:0] exp0_q[$];
  logic [DATA_SZ-1:0] exp1_q[$];
  logic               m_ptr;
  int                 m_cred;
  logic               pend0, pend1;
  int                 g0_cnt = 0, g1_cnt = 0;
  logic               e0, e1, g0, g1, x_acc, x_al, x_fr, x_rd, x_wr;
  logic [2:0]         x_op;
  logic [DATA_SZ-1:0] x_addr, x_data, x_rsp;

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_rv", {30'd0, rv0, rv1}, 32'd0);
      check_eq("rst_req", {30'd0, r0, r1}, 32'd0);
      check_eq("rst_strobe", {28'd0, hp.o_al, hp.o_fr, hp.o_rd, hp.o_wr}, 32'd0);
      m_ptr = 1'b0;
      m_cred = MEM_MAX;
      pend0 = 1'b0;
      pend1 = 1'b0;
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      check_eq("rv0", rv0, pend0);
      check_eq("rv1", rv1, pend1);
      if (rv0) begin
        if (exp0_q.size() == 0) check_eq("rdata0_noexp", 1, 0);
        else check_eq("rdata0", rdata, exp0_q.pop_front());
      end
      if (rv1) begin
        if (exp1_q.size() == 0) check_eq("rdata1_noexp", 1, 0);
        else check_eq("rdata1", rdata, exp1_q.pop_front());
      end
      if (!rv0 && !rv1) check_eq("rdata_idle", rdata, 0);
      check_eq("empty", empty, (m_cred == 0));

      e0 = v0 && ((op0 != 3'd3) || (m_cred != 0));
      e1 = v1 && ((op1 != 3'd3) || (m_cred != 0));
      g0 = m_ptr ? (e0 && !e1) : e0;
      g1 = m_ptr ? e1 : (e1 && !e0);
      check_eq("gnt0", r0, g0);
      check_eq("gnt1", r1, g1);

      x_acc  = g0 || g1;
      x_op   = g1 ? op1 : op0;
      x_addr = g1 ? addr1 : addr0;
      x_data = g1 ? data1 : data0;
      x_rd = x_acc && (x_op == 3'd1);
      x_wr = x_acc && (x_op == 3'd2);
      x_al = x_acc && ((x_op == 3'd3) || (x_op == 3'd5));
      x_fr = x_acc && ((x_op == 3'd4) || (x_op == 3'd5));
      check_eq("strobes", {28'd0, hp.o_al, hp.o_fr, hp.o_rd, hp.o_wr}, {28'd0, x_al, x_fr, x_rd, x_wr});
      check_eq("port_overlap", (hp.o_al | hp.o_fr) & (hp.o_rd | hp.o_wr), 0);
      check_eq("raddr", hp.o_raddr, x_rd ? x_addr : '0);
      check_eq("waddr", hp.o_waddr, x_wr ? x_addr : '0);
      check_eq("wdata", hp.o_wdata, x_wr ? x_data : '0);
      check_eq("adata", hp.o_adata, x_al ? x_data : '0);
      check_eq("faddr", hp.o_faddr, x_fr ? x_addr : '0);

      case (x_op)
        3'd1:       x_rsp = x_addr ^ 16'hA5A5;
        3'd3, 3'd5: x_rsp = x_data + 16'h0100;
        default:    x_rsp = 16'h0000;
      endcase
      if (g0) begin exp0_q.push_back(x_rsp); g0_cnt++; end
      if (g1) begin exp1_q.push_back(x_rsp); g1_cnt++; end
      pend0 = g0;
      pend1 = g1;
      if (g0) m_ptr = 1'b1;
      else if (g1) m_ptr = 1'b0;
      if (x_acc && (x_op == 3'd3)) m_cred--;
      else if (x_acc && (x_op == 3'd4) && (m_cred < MEM_MAX)) m_cred++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_c0(input logic v, input logic [2:0] op, input logic [DATA_SZ-1:0] a, input logic [DATA_SZ-1:0] d);
    v0 = v; op0 = op; addr0 = a; data0 = d;
  endtask

  task automatic set_c1(input logic v, input logic [2:0] op, input logic [DATA_SZ-1:0] a, input logic [DATA_SZ-1:0] d);
    v1 = v; op1 = op; addr1 = a; data1 = d;
  endtask

  task automatic idle_all();
    set_c0(1'b0, 3'd0, '0, '0);
    set_c1(1'b0, 3'd0, '0, '0);
  endtask

  int b0, b1;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    step(3);
    rst = 1'b0;
    check_eq("reset_empty", empty, 0);

    // Both clients read every cycle: alternating grants, 1-cycle responses.
    b0 = g0_cnt; b1 = g1_cnt;
    for (int i = 0; i < 8; i++) begin
      set_c0(1'b1, 3'd1, 16'($urandom_range(0, 16'hFFFF)), '0);
      set_c1(1'b1, 3'd1, 16'($urandom_range(0, 16'hFFFF)), '0);
      step(1);
    end
    check_eq("read_alt_g0", g0_cnt - b0, 4);
    check_eq("read_alt_g1", g1_cnt - b1, 4);

    // Five ALLOCs against four credits; a FREE from client 1 unblocks the fifth.
    idle_all();
    b0 = g0_cnt;
    set_c0(1'b1, 3'd3, '0, 16'h0A00);
    step(6);
    check_eq("alloc_accepted", g0_cnt - b0, 4);
    check_eq("alloc_empty", empty, 1);
    b0 = g0_cnt; b1 = g1_cnt;
    set_c1(1'b1, 3'd4, 16'h5001, '0);
    step(1);
    set_c1(1'b0, 3'd0, '0, '0);
    step(1);
    check_eq("free_unblock_g1", g1_cnt - b1, 1);
    check_eq("free_unblock_g0", g0_cnt - b0, 1);
    check_eq("refill_empty", empty, 1);

    // REALLOC while empty: both alloc and free strobes, credits stay at zero.
    set_c0(1'b1, 3'd5, 16'h5002, 16'h1234);
    #2;
    check_eq("realloc_strobes", {30'd0, hp.o_al, hp.o_fr}, 32'd3);
    step(1);
    set_c0(1'b0, 3'd0, '0, '0);
    check_eq("realloc_empty", empty, 1);

    // Blocked ALLOC on client 0 must not starve client 1 WRITEs.
    b0 = g0_cnt; b1 = g1_cnt;
    set_c0(1'b1, 3'd3, '0, 16'h0B00);
    for (int i = 0; i < 6; i++) begin
      set_c1(1'b1, 3'd2, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
      step(1);
    end
    check_eq("write_g1", g1_cnt - b1, 6);
    check_eq("write_g0", g0_cnt - b0, 0);

    // Illegal ops are accepted silently and answered with UNDEF.
    idle_all();
    set_c1(1'b1, 3'd7, 16'h1111, 16'h2222);
    step(1);
    set_c1(1'b0, 3'd0, '0, '0);
    set_c0(1'b1, 3'd0, 16'h3333, 16'h4444);
    step(1);
    set_c0(1'b1, 3'd6, 16'h5555, 16'h6666);
    step(1);

    // Five FREEs from zero credits (last one saturates), then ALLOCs drain to empty.
    idle_all();
    for (int i = 0; i < 5; i++) begin
      set_c1(1'b1, 3'd4, 16'(16'h5000 + i), '0);
      step(1);
    end
    idle_all();
    check_eq("sat_full", empty, 0);
    b1 = g1_cnt;
    set_c1(1'b1, 3'd3, '0, 16'h0C00);
    step(5);
    check_eq("sat_alloc", g1_cnt - b1, 4);
    check_eq("sat_empty", empty, 1);

    // Random mix on both clients.
    for (int i = 0; i < 60; i++) begin
      set_c0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
      set_c1(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
      step(1);
    end

    // Reset right after a READ is accepted: the response is dropped.
    idle_all();
    step(1);
    set_c0(1'b1, 3'd1, 16'h0042, '0);
    step(1);
    idle_all();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("post_rst_rv0", rv0, 0);
    check_eq("post_rst_empty", empty, 0);
    b0 = g0_cnt; b1 = g1_cnt;
    set_c0(1'b1, 3'd1, 16'h0010, '0);
    set_c1(1'b1, 3'd1, 16'h0020, '0);
    step(1);
    check_eq("post_rst_tie_g0", g0_cnt - b0, 1);
    check_eq("post_rst_tie_g1", g1_cnt - b1, 0);
    idle_all();
    step(2);
    check_eq("q0_drained", exp0_q.size(), 0);
    check_eq("q1_drained", exp1_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
